// File: rtl/lvds_align_pkg.sv
// Shared types and helpers for the LVDS word-alignment controller.
// Holds the FSM state enum, the default training word and a counter-width helper.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } align_state_t;

  localparam logic [7:0] DEFAULT_TRAIN_PAT = 8'hA5;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvds_pattern_chk.sv
// Compares deserialized words against the training word and counts consecutive
// valid matches; hit means the run is complete, mismatch flags a bad valid word.
module lvds_pattern_chk
  import lvds_align_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] TRAIN_PAT = DATA_W'(DEFAULT_TRAIN_PAT),
  parameter int                MATCH_CNT = 16,
  localparam int               CNT_W     = cnt_width(MATCH_CNT)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              hit,
  output logic              mismatch
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MATCH_CNT);

  logic [CNT_W-1:0] match_cnt;
  logic             word_ok;
  logic             full;

  assign word_ok  = (rx_data == TRAIN_PAT);
  assign full     = (match_cnt == CNT_MAX);
  assign hit      = enable && full;
  assign mismatch = enable && rx_valid && !word_ok;

  // Invalid cycles hold the count; leaving CHECK restarts it from zero.
  always_ff @(posedge sys_clk) begin
    if (rst || !enable || mismatch) begin
      match_cnt <= '0;
    end else if (rx_valid && word_ok && !full) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lvds_align_ctrl.sv
// LVDS word-alignment controller: sends the training word, slips the deserializer
// until it matches, then forwards user data. Define LVDS_ALIGN_STATS_EN for err_count.
module lvds_align_ctrl
  import lvds_align_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] TRAIN_PAT = DATA_W'(DEFAULT_TRAIN_PAT),
  parameter int                SLIP_WAIT = 4,
  parameter int                MATCH_CNT = 16,
  parameter int                MAX_SLIPS = 8,
  localparam int               SLIP_W    = cnt_width(MAX_SLIPS)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_user_data,
  output logic [DATA_W-1:0] tx_data,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              bitslip,
  output logic              locked,
  output logic              align_fail,
  output logic [SLIP_W-1:0] slip_count
`ifdef LVDS_ALIGN_STATS_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int                WAIT_W    = cnt_width(SLIP_WAIT);
  localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(MAX_SLIPS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

  align_state_t      state;
  align_state_t      state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_done;
  logic              hit;
  logic              mismatch;
  logic              restart;
  logic              slip_now;

  lvds_pattern_chk #(
    .DATA_W   (DATA_W),
    .TRAIN_PAT(TRAIN_PAT),
    .MATCH_CNT(MATCH_CNT)
  ) u_chk (
    .sys_clk (sys_clk),
    .rst     (rst),
    .enable  (state == CHECK),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .hit     (hit),
    .mismatch(mismatch)
  );

  assign wait_done = (wait_cnt == '0);
  assign restart   = start && ((state == IDLE) || (state == LOCKED) || (state == FAIL));
  // A slip is only issued on entry to SLIP while budget remains.
  assign slip_now  = (state_next == SLIP) && (slip_count != SLIP_MAX);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, LOCKED, FAIL: if (start) state_next = TRAIN;
      TRAIN, WAIT:        if (wait_done) state_next = CHECK;
      CHECK: begin
        if (hit)           state_next = LOCKED;
        else if (mismatch) state_next = SLIP;
      end
      SLIP:               state_next = bitslip ? WAIT : FAIL;
      default:            state_next = IDLE;
    endcase
  end

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data    <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      align_fail <= 1'b0;
      slip_count <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      bitslip    <= slip_now;
      locked     <= (state_next == LOCKED);
      align_fail <= (state_next == FAIL);
      if (state_next == IDLE)        tx_data <= '0;
      else if (state_next == LOCKED) tx_data <= tx_user_data;
      else                           tx_data <= TRAIN_PAT;
      if (restart)       slip_count <= '0;
      else if (slip_now) slip_count <= slip_count + SLIP_W'(1);
      if ((state_next != state) && ((state_next == TRAIN) || (state_next == WAIT)))
        wait_cnt <= WAIT_LOAD;
      else if (!wait_done)
        wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

`ifdef LVDS_ALIGN_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (rst || restart)                           err_count <= '0;
    else if (mismatch && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
  end
`endif

endmodule
